alu_shift_pipe: RTL and testbench
=================================

// Module: alu_shift_pipe
// PURPOSE
//   Parametrised, pipelined shift/rotate unit for the templatized ALU datapath.
//   Performs SLL, SRL, SAR, ROL and ROR on a WIDTH-bit operand A by amount B.
//   Results are defined for every shift amount, including 0 and values >= WIDTH.
//   Fixed-latency log-barrel pipeline with valid/ready handshakes on input and output.
// PARAMETERS
//   WIDTH   16  operand/result width; power of two, 4..64
//   STAGES  2   pipeline register stages (= latency); 1..$clog2(WIDTH)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      A/B/opcode valid this cycle
//   in_ready   out  1      unit can accept; transfer when in_valid && in_ready
//   A          in   WIDTH  operand
//   B          in   WIDTH  shift amount (unsigned)
//   opcode     in   4      0110 SLL, 0111 SAR, 1000 ROL, 1001 ROR, 1010 SRL
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer accepts; transfer when out_valid && out_ready
//   result     out  WIDTH  shifted/rotated value
//   zero       out  1      result == 0
//   illegal    out  1      opcode was not one of the five above
// BEHAVIOUR
//   - Reset (async assert, sync-released by rst falling): all stage valids, out_valid = 0,
//     result = 0, zero = 0, illegal = 0. Any in-flight ops are discarded.
//   - in_ready = !out_valid || out_ready (global stall). Pipe advances when in_ready = 1.
//     On stall, every stage register holds. result/zero/illegal must not change while
//     out_valid && !out_ready.
//   - Latency: an op accepted in cycle N shows out_valid in cycle N+STAGES when nothing
//     stalls. Throughput: 1 op/cycle. Order is preserved. Bubbles (in_valid = 0) propagate
//     as invalid stages.
//   - Let L = $clog2(WIDTH) and s = B[L-1:0]. Let big = |B[WIDTH-1:L].
//       SLL: big ? 0 : A << s
//       SRL: big ? 0 : A >> s
//       SAR: big ? {WIDTH{A[WIDTH-1]}} : $signed(A) >>> s
//       ROL: rotate left by s (B modulo WIDTH); s = 0 gives A
//       ROR: rotate right by s; s = 0 gives A
//       other opcode: result = 0, illegal = 1
//   - Barrel levels 2^0..2^(L-1) are distributed across STAGES in order, ceil(L/STAGES)
//     levels per stage. opcode, big and the remaining shift bits are carried alongside.
//   - zero is computed from the final result in the last stage. It is registered with
//     result. illegal is registered with result.
//   - When out_valid = 0, result/zero/illegal keep their last value. Verify them only when
//     out_valid = 1.
//   - A reset asserted mid-operation clears out_valid asynchronously, the same cycle.
//     No stale result emerges after release.
// TESTING (WIDTH=16, STAGES=2, out_ready=1 unless stated)
//   1. SAR A=16'h8000 B=4 -> after 2 cycles out_valid=1, result=16'hF800, zero=0.
//      SAR A=16'h8000 B=17 -> result=16'hFFFF.
//   2. ROL A=16'h8001 B=1 -> 16'h0003. ROR A=16'h0001 B=16 -> 16'h0001.
//      ROL A=16'h1234 B=0 -> 16'h1234.
//   3. SLL A=16'h00FF B=20 -> result=0, zero=1. SRL A=16'hF000 B=12 -> 16'h000F.
//   4. Back-to-back 4 ops, out_ready=0 from the first out_valid for 3 cycles:
//      in_ready=0, result stable, then results emerge in issue order, none lost or duplicated.
//   5. opcode=4'b0000, A=16'hFFFF -> result=0, illegal=1, zero=1. Next legal op -> illegal=0.
//   6. Assert rst with 2 ops in flight -> out_valid=0 immediately.
//      After release, no output until a new op is accepted.

Source files
------------

// File: rtl/alu_shift_pipe_if.sv
// Valid/ready bus of the shift/rotate pipeline: request side (A, B, opcode) and
// result side (result, zero, illegal). The master drives requests and out_ready.
interface alu_shift_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, A, B, opcode, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, A, B, opcode, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_shift_pipe.sv
// Pipelined log-barrel shift/rotate unit (SLL/SRL/SAR/ROL/ROR) with a global valid/ready
// stall. Barrel levels are spread over STAGES registers; result/zero/illegal leave the last.
module alu_shift_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_shift_pipe_if.slave bus
);
    localparam int L   = $clog2(WIDTH);
    localparam int LPS = (L + STAGES - 1) / STAGES;

    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SAR = 4'b0111;
    localparam logic [3:0] OP_ROL = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;

    // Stage registers
    logic             vld_q   [STAGES];
    logic [WIDTH-1:0] data_q  [STAGES];
    logic [3:0]       op_q    [STAGES];
    logic             big_q   [STAGES];
    logic [L-1:0]     s_q     [STAGES];
    logic             zero_q;
    logic             illegal_q;

    // Stage inputs and combinational next state
    logic             vld_in  [STAGES];
    logic [WIDTH-1:0] data_in [STAGES];
    logic [3:0]       op_in   [STAGES];
    logic             big_in  [STAGES];
    logic [L-1:0]     s_in    [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] final_d;
    logic             zero_d;
    logic             illegal_d;
    logic             advance;

    // One barrel level: shift/rotate d by the constant amount amt (0 < amt < WIDTH).
    function automatic logic [WIDTH-1:0] level_shift(
        input logic [WIDTH-1:0] d,
        input logic [3:0]       op,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SAR:  r = $signed(d) >>> amt;
            OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
            OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
            default: r = d;
        endcase
        return r;
    endfunction

    assign advance       = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.result    = data_q[STAGES-1];
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO = gi * LPS;
        localparam int HI = ((gi + 1) * LPS > L) ? L : (gi + 1) * LPS;
        localparam int N  = (HI > LO) ? HI - LO : 0;

        logic [WIDTH-1:0] chain [N+1];

        if (gi == 0) begin : g_head
            assign vld_in[gi]  = bus.in_valid;
            assign data_in[gi] = bus.A;
            assign op_in[gi]   = bus.opcode;
            assign big_in[gi]  = |bus.B[WIDTH-1:L];
            assign s_in[gi]    = bus.B[L-1:0];
        end else begin : g_body
            assign vld_in[gi]  = vld_q[gi-1];
            assign data_in[gi] = data_q[gi-1];
            assign op_in[gi]   = op_q[gi-1];
            assign big_in[gi]  = big_q[gi-1];
            assign s_in[gi]    = s_q[gi-1];
        end

        assign chain[0] = data_in[gi];
        for (genvar gj = 0; gj < N; gj++) begin : g_level
            assign chain[gj+1] = s_in[gi][LO+gj]
                               ? level_shift(chain[gj], op_in[gi], 1 << (LO + gj))
                               : chain[gj];
        end
        assign stage_d[gi] = chain[N];

        // Payload only loads for valid ops, so outputs keep their last value across bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q[gi]  <= 1'b0;
                data_q[gi] <= '0;
                op_q[gi]   <= '0;
                big_q[gi]  <= 1'b0;
                s_q[gi]    <= '0;
            end else if (advance) begin
                vld_q[gi] <= vld_in[gi];
                if (vld_in[gi]) begin
                    data_q[gi] <= (gi == STAGES - 1) ? final_d : stage_d[gi];
                    op_q[gi]   <= op_in[gi];
                    big_q[gi]  <= big_in[gi];
                    s_q[gi]    <= s_in[gi];
                end
            end
        end
    end

    // Out-of-range amounts: logical shifts flush to 0, SAR floods with the sign bit,
    // which arithmetic shifting has kept in the MSB of the partial result.
    always_comb begin
        final_d   = stage_d[STAGES-1];
        illegal_d = 1'b0;
        case (op_in[STAGES-1])
            OP_SLL, OP_SRL: begin
                if (big_in[STAGES-1]) final_d = '0;
            end
            OP_SAR: begin
                if (big_in[STAGES-1]) final_d = {WIDTH{stage_d[STAGES-1][WIDTH-1]}};
            end
            OP_ROL, OP_ROR: begin
                final_d = stage_d[STAGES-1];
            end
            default: begin
                final_d   = '0;
                illegal_d = 1'b1;
            end
        endcase
        zero_d = (final_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (advance && vld_in[STAGES-1]) begin
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_shift_pipe.sv
// Randomized and directed bench for alu_shift_pipe (WIDTH=16, STAGES=2) against a
// plain-arithmetic reference model and an in-order scoreboard.
module tb_alu_shift_pipe;
    localparam int W = 16;

    typedef struct {
        logic [15:0] res;
        logic        zero;
        logic        ill;
        int          issue;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    alu_shift_pipe_if #(.WIDTH(W)) bus ();

    alu_shift_pipe #(.WIDTH(W), .STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          lat_en   = 1'b0;
    bit          in_fire  = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] held_res;
    logic        held_zero, held_ill;
    logic [15:0] last_res;
    logic        last_zero, last_ill;

    logic [3:0]  dir_op [11] = '{4'h7, 4'h7, 4'h8, 4'h9, 4'h8, 4'h6, 4'hA, 4'h0, 4'h6, 4'hA, 4'h7};
    logic [15:0] dir_a  [11] = '{16'h8000, 16'h8000, 16'h8001, 16'h0001, 16'h1234, 16'h00FF,
                                 16'hF000, 16'hFFFF, 16'h0003, 16'h8000, 16'h7FFF};
    logic [15:0] dir_b  [11] = '{16'd4, 16'd17, 16'd1, 16'd16, 16'd0, 16'd20,
                                 16'd12, 16'd3, 16'd1, 16'd15, 16'd16};
    logic [15:0] dir_r  [11] = '{16'hF800, 16'hFFFF, 16'h0003, 16'h0001, 16'h1234, 16'h0000,
                                 16'h000F, 16'h0000, 16'h0006, 16'h0001, 16'h0000};
    logic        dir_il [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: amount taken as a plain number; rotates use a doubled operand.
    function automatic exp_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                       input logic [3:0] op);
        exp_t        e;
        logic [31:0] dbl;
        int          s;
        dbl   = {a, a};
        s     = int'(b) % 16;
        e.ill = 1'b0;
        case (op)
            4'b0110: e.res = (b >= 16) ? 16'h0 : (a << b);
            4'b1010: e.res = (b >= 16) ? 16'h0 : (a >> b);
            4'b0111: e.res = (b >= 16) ? {16{a[15]}} : 16'($signed(a) >>> b);
            4'b1000: begin dbl = dbl << s; e.res = dbl[31:16]; end
            4'b1001: begin dbl = dbl >> s; e.res = dbl[15:0];  end
            default: begin e.res = 16'h0; e.ill = 1'b1; end
        endcase
        e.zero  = (e.res == 16'h0);
        e.issue = cyc;
        return e;
    endfunction

    // One clock cycle: sample mid-cycle, score outputs, record accepted input.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        in_fire = bus.in_valid && bus.in_ready;
        if (bus.out_valid && !bus.out_ready) check("in_ready_stall", bus.in_ready, 0);
        if (prev_stall) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_result", bus.result, held_res);
            check("hold_zero", bus.zero, held_zero);
            check("hold_illegal", bus.illegal, held_ill);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        held_res   = bus.result;
        held_zero  = bus.zero;
        held_ill   = bus.illegal;
        if (bus.out_valid && bus.out_ready) begin
            check("out_has_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("result", bus.result, e.res);
                check("zero", bus.zero, e.zero);
                check("illegal", bus.illegal, e.ill);
                if (lat_en) check("latency", cyc - e.issue, 2);
                last_res  = bus.result;
                last_zero = bus.zero;
                last_ill  = bus.illegal;
                $display("txn cyc=%0d result=%h zero=%0b illegal=%0b (exp %h)",
                         cyc, bus.result, bus.zero, bus.illegal, e.res);
            end
        end
        if (in_fire) q.push_back(ref_model(bus.A, bus.B, bus.opcode));
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        bit done;
        done = 1'b0;
        bus.A = a; bus.B = b; bus.opcode = op; bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            cycle();
            done = in_fire;
        end
        if (!done) check("send_accepted", done, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.opcode = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_illegal", bus.illegal, 0);
        rst = 1'b0;

        // Directed single ops, checked against fixed values and for 2-cycle latency
        lat_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send(dir_a[i], dir_b[i], dir_op[i]);
            drain();
            check("dir_result", last_res, dir_r[i]);
            check("dir_zero", last_zero, dir_r[i] == 16'h0);
            check("dir_illegal", last_ill, dir_il[i]);
        end
        lat_en = 1'b0;

        // Back-to-back ops with a 3-cycle output stall at the first out_valid
        send(16'h00F0, 16'd2, 4'h6);
        send(16'h8421, 16'd5, 4'h8);
        bus.out_ready = 1'b0;
        bus.A = 16'hC003; bus.B = 16'd3; bus.opcode = 4'h9; bus.in_valid = 1'b1;
        repeat (3) cycle();
        bus.out_ready = 1'b1;
        send(16'hC003, 16'd3, 4'h9);
        send(16'h9000, 16'd1, 4'h7);
        drain();

        // Reset with two ops in flight
        send(16'h1111, 16'd1, 4'h6);
        send(16'h2222, 16'd2, 4'hA);
        check("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", bus.out_valid, 0);
        check("rst_async_result", bus.result, 0);
        q.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("post_rst_idle", bus.out_valid, 0);
        end
        lat_en = 1'b1;
        send(16'h0F0F, 16'd4, 4'h8);
        drain();
        check("post_rst_result", last_res, 16'hF0F0);
        lat_en = 1'b0;

        // Randomized traffic with random back-pressure
        in_fire = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid || in_fire) begin
                int k;
                k = $urandom_range(0, 5);
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.A = 16'($urandom);
                bus.B = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
                case (k)
                    0: bus.opcode = 4'h6;
                    1: bus.opcode = 4'h7;
                    2: bus.opcode = 4'h8;
                    3: bus.opcode = 4'h9;
                    4: bus.opcode = 4'hA;
                    default: bus.opcode = 4'($urandom_range(0, 15));
                endcase
            end
            cycle();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
